nes_rom_loader: RTL and testbench
=================================

# nes_rom_loader

Consumes the byte stream the IO subsystem emits during ROM loading (`rom_loading`, `rom_do`, `rom_do_valid`) and turns it into a loaded cartridge image. It parses the 16-byte iNES header, discards any 512-byte trainer, and writes PRG and CHR bytes into SDRAM through a small FIFO and a req/ack handshake. It exports the decoded cartridge fields to the NES core and reports completion or error.

## Interface
- `FIFO_DEPTH`, 8: entries in the write FIFO; power of two, minimum 4.
- `CHR_BASE`, 22'h200000: SDRAM byte address of CHR byte 0. PRG starts at 0.

- `clk` in 1: NES mclk; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rom_loading` in 1: high while a ROM transfer is in progress.
- `rom_do` in 8: stream byte.
- `rom_do_valid` in 1: one-cycle strobe per byte; up to 4 consecutive cycles per burst.
- `mem_req` out 1: FIFO head valid; held until acked.
- `mem_addr` out 22: byte address of head entry.
- `mem_wdata` out 8: byte data of head entry.
- `mem_ack` in 1: one-cycle pulse; pops the head in the same cycle.
- `mapper` out 8: {byte7[7:4], byte6[7:4]}.
- `mirroring` out 1: byte6[0].
- `battery` out 1: byte6[1].
- `prg_banks` out 8: byte4, in 16 KB units.
- `chr_banks` out 8: byte5, in 8 KB units; 0 means CHR RAM.
- `header_valid` out 1: decoded fields are valid.
- `done` out 1: image fully written.
- `error` out 1: load failed (sticky until restart).
- `err_code` out 2: 0 none, 1 bad header, 2 truncated, 3 FIFO overflow.

## Operation
- States: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR. A byte is "accepted" when `rom_do_valid=1` in a state that consumes it.
- Rising edge of `rom_loading` (in any state): clear all status, fields, counters and the FIFO, then enter HEADER.
- HEADER:
  - Count accepted bytes 0..15 and latch bytes 4–7 into the fields.
  - If bytes 0–3 are not 4E 45 53 1A: ERROR, code 1, checked at the offending byte.
  - After byte 15:
    - byte4 == 0 or byte4 > 128: ERROR, code 1.
    - Otherwise assert `header_valid`, then go to TRAINER if byte6[2] is set, else PRG.
- TRAINER: discard 512 bytes, then go to PRG.
- PRG:
  - Push {addr, byte}; addr runs 0 .. byte4*16384−1 (21-bit counter).
  - After the last byte: CHR if byte5 ≠ 0, else DONE.
- CHR:
  - Push {CHR_BASE + offset, byte}; offset runs 0 .. byte5*8192−1.
  - After the last byte: DONE.
- DONE: further stream bytes are ignored. `done` = state DONE and FIFO empty.
- ERROR: bytes are ignored. The FIFO keeps draining, so writes already queued complete.
- `rom_loading` falling edge in HEADER/TRAINER/PRG/CHR: ERROR, code 2.
- Overflow: a push while the FIFO is full and no `mem_ack` arrives that cycle drops the byte and goes to ERROR, code 3.
- FIFO entries are 30 bits {addr[21:0], data[7:0]}. `mem_req` = not empty. `mem_addr`/`mem_wdata` come from the head register.
- Simultaneous push and pop:
  - Allowed, including when the FIFO is full; the count is unchanged.
  - When the FIFO is empty, a push and pop in the same cycle is impossible because `mem_ack` is only valid while `mem_req=1`.
- `mem_ack` while `mem_req=0` is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `mem_req`, `mem_addr`, `mem_wdata`, fields, `header_valid`, `done`, `error`, `err_code`.
  - FIFO empty, counters 0.
- Edge detection uses `rom_loading` registered once; the state changes 1 cycle after the input edge.
- A byte accepted at edge N appears as `mem_req=1` with its addr/data after edge N if the FIFO was empty (latency 1).
- `header_valid` rises at the edge that accepts byte 15. Fields change only at the edges accepting bytes 4–7.
- `done` rises the cycle after the last entry's `mem_ack`. If CHR is empty and the FIFO is already drained, it rises after the last PRG byte's ack.
- `error`/`err_code` are registered and rise 1 cycle after the triggering event.
- Sustained throughput needs the average ack rate to be at least the byte rate. A 4-byte burst fits in an empty FIFO with no acks.

## Test plan
- Valid header (prg=1, chr=1, byte6=0x11, byte7=0x00), then 24576 bytes, acked every cycle:
  - Writes go to 0x000000–0x003FFF, then 0x200000–0x201FFF.
  - `mapper`=1, `mirroring`=1, `done`=1, no error.
- Trainer bit set: the 512 bytes after the header are never written; the first PRG byte goes to address 0.
- Magic byte 3 = 0x1B: ERROR, `err_code`=1, no `mem_req` ever asserted. byte4=0 gives the same result.
- `rom_loading` drops after 100 PRG bytes: `err_code`=2, and the 100 queued writes still drain.
- Hold `mem_ack`=0 with FIFO_DEPTH=8 and send 3 bursts of 4:
  - The 9th PRG byte sets `err_code`=3.
  - The FIFO holds exactly 8 entries, with addresses 0–7.
- Second rising edge of `rom_loading` after DONE: all status clears, and the header is re-parsed with the new mapper value.

Source files
------------

// File: rtl/nes_rom_loader.sv
// iNES ROM loader: parses the 16-byte header, skips an optional trainer and
// queues PRG/CHR bytes into a small write FIFO drained by a req/ack SDRAM port.
module nes_rom_loader #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [21:0] CHR_BASE   = 22'h200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic [7:0]  mapper,
    output logic        mirroring,
    output logic        battery,
    output logic [7:0]  prg_banks,
    output logic [7:0]  chr_banks,
    output logic        header_valid,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] MAGIC = 32'h1A53454E;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_TRUNC = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR
    } state_t;

    state_t      state_reg, state_next;
    logic        loading_reg;
    logic [21:0] cnt_reg, cnt_next;
    logic [7:0]  prg_banks_reg, prg_banks_next;
    logic [7:0]  chr_banks_reg, chr_banks_next;
    logic [7:0]  mapper_reg, mapper_next;
    logic        mirroring_reg, mirroring_next;
    logic        battery_reg, battery_next;
    logic        trainer_reg, trainer_next;
    logic        hv_reg, hv_next;
    logic [1:0]  err_reg, err_next;

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_after_pop;
    logic [29:0]   head_reg;
    logic [29:0]   fifo_mem [FIFO_DEPTH];

    logic        rise, fall, consuming;
    logic        push, pop, fifo_full, overflow, do_write, fifo_clear;
    logic [21:0] push_addr;
    logic [21:0] prg_last, chr_last;

    assign rise      = rom_loading & ~loading_reg;
    assign fall      = ~rom_loading & loading_reg;
    assign consuming = (state_reg == S_HEADER) || (state_reg == S_TRAINER) ||
                       (state_reg == S_PRG)    || (state_reg == S_CHR);

    assign pop       = mem_ack && (count_reg != '0);
    assign fifo_full = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign overflow  = fifo_full && !pop;
    assign do_write  = push && !overflow;

    assign prg_last = {prg_banks_reg, 14'd0} - 22'd1;
    assign chr_last = {1'b0, chr_banks_reg, 13'd0} - 22'd1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        prg_banks_next = prg_banks_reg;
        chr_banks_next = chr_banks_reg;
        mapper_next    = mapper_reg;
        mirroring_next = mirroring_reg;
        battery_next   = battery_reg;
        trainer_next   = trainer_reg;
        hv_next        = hv_reg;
        err_next       = err_reg;
        push           = 1'b0;
        push_addr      = '0;
        fifo_clear     = 1'b0;

        if (rise) begin
            fifo_clear     = 1'b1;
            state_next     = S_HEADER;
            cnt_next       = '0;
            prg_banks_next = '0;
            chr_banks_next = '0;
            mapper_next    = '0;
            mirroring_next = 1'b0;
            battery_next   = 1'b0;
            trainer_next   = 1'b0;
            hv_next        = 1'b0;
            err_next       = ERR_NONE;
        end else if (fall && consuming) begin
            state_next = S_ERROR;
            err_next   = ERR_TRUNC;
        end else if (rom_do_valid) begin
            case (state_reg)
                S_HEADER: begin
                    cnt_next = cnt_reg + 22'd1;
                    case (cnt_reg[3:0])
                        4'd4: prg_banks_next = rom_do;
                        4'd5: chr_banks_next = rom_do;
                        4'd6: begin
                            mapper_next[3:0] = rom_do[7:4];
                            trainer_next     = rom_do[2];
                            battery_next     = rom_do[1];
                            mirroring_next   = rom_do[0];
                        end
                        4'd7: mapper_next[7:4] = rom_do[7:4];
                        default: ;
                    endcase
                    if (cnt_reg < 22'd4 && rom_do != MAGIC[8*cnt_reg[1:0] +: 8]) begin
                        state_next = S_ERROR;
                        err_next   = ERR_HDR;
                    end else if (cnt_reg == 22'd15) begin
                        if (prg_banks_reg == 8'd0 || prg_banks_reg > 8'd128) begin
                            state_next = S_ERROR;
                            err_next   = ERR_HDR;
                        end else begin
                            hv_next    = 1'b1;
                            cnt_next   = '0;
                            state_next = trainer_reg ? S_TRAINER : S_PRG;
                        end
                    end
                end
                S_TRAINER: begin
                    if (cnt_reg == 22'd511) begin
                        cnt_next   = '0;
                        state_next = S_PRG;
                    end else begin
                        cnt_next = cnt_reg + 22'd1;
                    end
                end
                S_PRG: begin
                    push      = 1'b1;
                    push_addr = cnt_reg;
                    if (overflow) begin
                        state_next = S_ERROR;
                        err_next   = ERR_OVF;
                    end else if (cnt_reg == prg_last) begin
                        cnt_next   = '0;
                        state_next = (chr_banks_reg != 8'd0) ? S_CHR : S_DONE;
                    end else begin
                        cnt_next = cnt_reg + 22'd1;
                    end
                end
                S_CHR: begin
                    push      = 1'b1;
                    push_addr = CHR_BASE + cnt_reg;
                    if (overflow) begin
                        state_next = S_ERROR;
                        err_next   = ERR_OVF;
                    end else if (cnt_reg == chr_last) begin
                        cnt_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg + 22'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            loading_reg   <= 1'b0;
            cnt_reg       <= '0;
            prg_banks_reg <= '0;
            chr_banks_reg <= '0;
            mapper_reg    <= '0;
            mirroring_reg <= 1'b0;
            battery_reg   <= 1'b0;
            trainer_reg   <= 1'b0;
            hv_reg        <= 1'b0;
            err_reg       <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            loading_reg   <= rom_loading;
            cnt_reg       <= cnt_next;
            prg_banks_reg <= prg_banks_next;
            chr_banks_reg <= chr_banks_next;
            mapper_reg    <= mapper_next;
            mirroring_reg <= mirroring_next;
            battery_reg   <= battery_next;
            trainer_reg   <= trainer_next;
            hv_reg        <= hv_next;
            err_reg       <= err_next;
        end
    end

    // Storage array has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr_reg] <= {push_addr, rom_do};
        end
    end

    assign rd_ptr_next     = rd_ptr_reg + (pop ? AW'(1) : AW'(0));
    assign count_after_pop = count_reg - (pop ? (AW+1)'(1) : (AW+1)'(0));

    // The head register is refilled from the array, or bypassed straight from
    // the write port when the pushed entry becomes the head this cycle.
    always_ff @(posedge clk) begin
        if (reset || fifo_clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_after_pop + (do_write ? (AW+1)'(1) : (AW+1)'(0));
            if (do_write && count_after_pop == '0) begin
                head_reg <= {push_addr, rom_do};
            end else if (count_after_pop != '0) begin
                head_reg <= fifo_mem[rd_ptr_next];
            end
        end
    end

    assign mem_req      = (count_reg != '0);
    assign mem_addr     = head_reg[29:8];
    assign mem_wdata    = head_reg[7:0];
    assign mapper       = mapper_reg;
    assign mirroring    = mirroring_reg;
    assign battery      = battery_reg;
    assign prg_banks    = prg_banks_reg;
    assign chr_banks    = chr_banks_reg;
    assign header_valid = hv_reg;
    assign err_code     = err_reg;
    assign error        = (err_reg != ERR_NONE);
    assign done         = (state_reg == S_DONE) && (count_reg == '0);

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed bench for nes_rom_loader: header parsing, trainer skip, PRG/CHR
// addressing, truncation, overflow and reload behaviour.
module tb_nes_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rom_loading;
    logic [7:0]  rom_do;
    logic        rom_do_valid;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mapper;
    logic        mirroring;
    logic        battery;
    logic [7:0]  prg_banks;
    logic [7:0]  chr_banks;
    logic        header_valid;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        ack_en;

    int n_vec = 0;
    int n_bad = 0;
    int burst = 0;
    bit req_seen;
    logic [29:0] wq[$];

    always #5 clk = ~clk;

    assign mem_ack = ack_en & mem_req;

    nes_rom_loader #(.FIFO_DEPTH(8), .CHR_BASE(22'h200000)) dut (
        .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
        .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mapper(mapper),
        .mirroring(mirroring), .battery(battery), .prg_banks(prg_banks),
        .chr_banks(chr_banks), .header_valid(header_valid), .done(done),
        .error(error), .err_code(err_code)
    );

    // Log every completed SDRAM write and note any request at all.
    always @(posedge clk) begin
        if (mem_req && mem_ack) wq.push_back({mem_addr, mem_wdata});
        if (mem_req) req_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        if (burst == 4) begin
            tick();
            burst = 0;
        end
        rom_do       = b;
        rom_do_valid = 1'b1;
        tick();
        rom_do_valid = 1'b0;
        burst++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
        burst = 0;
    endtask

    task automatic start_load();
        rom_loading = 1'b0;
        tick();
        rom_loading = 1'b1;
        tick();
        burst    = 0;
        wq.delete();
        req_seen = 1'b0;
    endtask

    task automatic header(input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7, input bit exp_hv);
        send(8'h4E); send(8'h45); send(8'h53); send(8'h1A);
        send(b4); send(b5); send(b6); send(b7);
        for (int i = 8; i < 15; i++) send(8'h00);
        check("hv_before_byte15", header_valid, 0);
        send(8'h00);
        check("hv_after_byte15", header_valid, exp_hv);
    endtask

    initial begin
        int bad;
        logic [21:0] ea;
        logic [7:0]  ed;
        logic [15:0] iv;

        reset = 1'b1; rom_loading = 1'b0; rom_do = 8'h00; rom_do_valid = 1'b0; ack_en = 1'b0;
        idle(3);
        reset = 1'b0;
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_header_valid", header_valid, 0);
        check("rst_mapper", mapper, 0);
        check("rst_prg_banks", prg_banks, 0);

        // 16 KB PRG + 8 KB CHR, acked every cycle
        ack_en = 1'b1;
        start_load();
        header(8'd1, 8'd1, 8'h11, 8'h00, 1'b1);
        check("t1_mapper", mapper, 8'h01);
        check("t1_mirroring", mirroring, 1);
        check("t1_battery", battery, 0);
        check("t1_prg_banks", prg_banks, 1);
        check("t1_chr_banks", chr_banks, 1);
        for (int i = 0; i < 24576; i++) begin
            iv = 16'(i);
            send(iv[7:0] ^ iv[15:8]);
        end
        idle(2);
        check("t1_done", done, 1);
        check("t1_error", error, 0);
        check("t1_write_count", wq.size(), 24576);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            iv = 16'(i);
            ea = (i < 16384) ? 22'(i) : 22'h200000 + 22'(i - 16384);
            ed = iv[7:0] ^ iv[15:8];
            if (wq[i] !== {ea, ed}) bad++;
        end
        check("t1_write_contents", bad, 0);

        // Reload after DONE with a different mapper and no CHR
        start_load();
        check("t6_done_cleared", done, 0);
        check("t6_hv_cleared", header_valid, 0);
        check("t6_mapper_cleared", mapper, 0);
        header(8'd1, 8'd0, 8'h42, 8'h10, 1'b1);
        check("t6_mapper", mapper, 8'h14);
        check("t6_mirroring", mirroring, 0);
        check("t6_battery", battery, 1);
        for (int i = 0; i < 16384; i++) begin
            iv = 16'(i);
            send(iv[7:0]);
        end
        idle(2);
        check("t6_done", done, 1);
        check("t6_write_count", wq.size(), 16384);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            iv = 16'(i);
            if (wq[i] !== {22'(i), iv[7:0]}) bad++;
        end
        check("t6_write_contents", bad, 0);

        // Trainer skip, then truncation with writes still queued
        start_load();
        header(8'd1, 8'd0, 8'h04, 8'h00, 1'b1);
        for (int i = 0; i < 512; i++) send(8'hEE);
        for (int i = 0; i < 96; i++) send(8'(i));
        ack_en = 1'b0;
        for (int i = 96; i < 100; i++) send(8'(i));
        check("t2_pending_req", mem_req, 1);
        rom_loading = 1'b0;
        tick();
        check("t2_error", error, 1);
        check("t2_err_code", err_code, 2);
        ack_en = 1'b1;
        idle(10);
        check("t2_drained_req", mem_req, 0);
        check("t2_write_count", wq.size(), 100);
        check("t2_first_write", (wq.size() > 0) ? wq[0] : 30'h3FFFFFFF, 30'h0);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] !== {22'(i), 8'(i)}) bad++;
        end
        check("t2_write_contents", bad, 0);
        check("t2_done", done, 0);

        // Bad magic byte 3
        start_load();
        check("t3_error_cleared", error, 0);
        send(8'h4E); send(8'h45); send(8'h53);
        check("t3_error_before", error, 0);
        send(8'h1B);
        check("t3_error", error, 1);
        check("t3_err_code", err_code, 1);
        for (int i = 0; i < 20; i++) send(8'(i));
        idle(2);
        check("t3_no_req", req_seen, 0);
        check("t3_hv", header_valid, 0);

        // byte4 == 0
        start_load();
        check("t3b_err_cleared", err_code, 0);
        header(8'd0, 8'd1, 8'h00, 8'h00, 1'b0);
        check("t3b_error", error, 1);
        check("t3b_err_code", err_code, 1);
        for (int i = 0; i < 20; i++) send(8'(i));
        idle(2);
        check("t3b_no_req", req_seen, 0);

        // Overflow with acks held off: 3 bursts of 4
        ack_en = 1'b0;
        start_load();
        header(8'd2, 8'd0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        check("t5_no_error_at_8", error, 0);
        check("t5_req", mem_req, 1);
        send(8'h38);
        check("t5_error", error, 1);
        check("t5_err_code", err_code, 3);
        for (int i = 9; i < 12; i++) send(8'h30 + 8'(i));
        ack_en = 1'b1;
        idle(12);
        check("t5_write_count", wq.size(), 8);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] !== {22'(i), 8'h30 + 8'(i)}) bad++;
        end
        check("t5_write_contents", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
